fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer between the program counter and decode. It reads instruction memory at the current PC and presents the fetched word to decode through a valid/ready handshake. It is the only driver of the program counter's `pc_we`/`pc_next`, advancing sequentially on each accepted instruction and loading a target when the execution FSM redirects.

## Interface
- `ADDR_W`, 10 (from `params_pkg`), instruction index width
- `INSTR_W`, 16 (from `params_pkg`), instruction word width

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `run`  in  1  fetch enable from execution FSM
- `pc_curr`  in  ADDR_W  current PC from `pc`
- `pc_inc`  in  ADDR_W  pc_curr+1 from `pc`
- `pc_we`  out  1  PC write enable to `pc`
- `pc_next`  out  ADDR_W  PC load value to `pc`
- `imem_en`  out  1  instruction memory read strobe
- `imem_addr`  out  ADDR_W  instruction memory address
- `imem_rdata`  in  INSTR_W  read data, valid the cycle after `imem_en`
- `redirect_valid`  in  1  branch/jump taken, single-cycle pulse
- `redirect_target`  in  ADDR_W  new PC on redirect
- `instr`  out  INSTR_W  fetched instruction
- `instr_pc`  out  ADDR_W  index the held instruction came from
- `instr_valid`  out  1  `instr` valid to decode
- `instr_ready`  in  1  decode accepts
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, RESP, HOLD.
- IDLE: `run`=1 -> REQ; else stay.
- REQ: `imem_en`=1, `imem_addr`=`pc_curr`; latch `pc_curr` into an internal pending-PC register; -> RESP.
- RESP: capture `imem_rdata` into `instr` and the pending PC into `instr_pc`; set `instr_valid`; -> HOLD.
- HOLD: `instr`/`instr_pc` stable while `instr_valid`=1 and `instr_ready`=0. On handshake (`instr_valid`&`instr_ready`): `pc_we`=1, `pc_next`=`pc_inc`; clear `instr_valid`; -> REQ if `run`, else IDLE.
- Redirect, any state, highest priority: `pc_we`=1, `pc_next`=`redirect_target`; clear `instr_valid`. A read in flight in RESP is discarded and `instr` is not updated. Next state: REQ if `run`, else IDLE.
- Redirect together with handshake in HOLD: decode's transfer counts, and PC loads `redirect_target`, not `pc_inc`.
- `run` deassertion is honoured only at decision points, IDLE and handshake exit. A REQ/RESP already started completes into HOLD.
- PC wrap: `pc_inc` wraps from 2^ADDR_W-1 to 0 inside `pc`. No special handling here.
- `pc_we`=0 in every cycle without a handshake or redirect. `pc_next` then equals `pc_inc`, which `pc` ignores.

## Timing
- Reset values: state IDLE, `instr_valid`=0, `instr`=0, `instr_pc`=0, pending PC=0, `busy`=0. Combinational outputs under reset: `pc_we`=0, `imem_en`=0, `imem_addr`=`pc_curr`.
- Reset mid-operation overrides redirect and handshake: no `pc_we` in the reset cycle, and any held instruction is dropped.
- `pc_we`, `pc_next`, `imem_en` and `imem_addr` are combinational from state and inputs. `instr`, `instr_pc` and `instr_valid` are registered.
- Latency, with `run`=1 sampled in IDLE at cycle k: REQ at k+1, RESP at k+2, `instr_valid`=1 from k+3.
- Sequential throughput with `instr_ready` tied high: one instruction every 3 cycles (REQ, RESP, HOLD).
- The PC update lands at the edge ending the handshake cycle. The following REQ sees the new `pc_curr`.

## Structure
- `params_pkg`: `ADDR_W`, `INSTR_W`, and `typedef enum logic [1:0] {FS_IDLE, FS_REQ, FS_RESP, FS_HOLD} fetch_state_t`.
- Single module, no sub-modules. One `always_ff` for state and registers, one `always_comb` for next state and strobes.
- The bench instantiates `pc` and a synchronous-read ROM model alongside `fetch_unit`.

## Test plan
- Reset, then `run`=1, `instr_ready`=1, ROM[i]=0xA000+i -> `instr`=0xA000,0xA001,0xA002 with `instr_pc`=0,1,2; `instr_valid` first high 3 cycles after `run`; one-cycle `pc_we` pulse per instruction.
- `instr_ready` held low 5 cycles in HOLD -> `instr`/`instr_pc` stable, `pc_we`=0 throughout; the single handshake advances PC by exactly 1.
- `redirect_valid` with target 0x155 during RESP -> that cycle's `imem_rdata` discarded, `pc_curr`=0x155 next cycle, next `instr_pc`=0x155.
- Redirect together with handshake in HOLD, target 0x020 -> one transfer counted, PC=0x020 (not `pc_inc`), next fetch from 0x020.
- PC preset to 0x3FF (via redirect), sequential accept -> `instr_pc`=0x3FF, then next `instr_pc`=0x000.
- `rst` asserted while in HOLD with `instr_valid`=1 -> next cycle `instr_valid`=0, state IDLE, PC=0, no `pc_we` in the reset cycle; `run`=0 at handshake -> IDLE, `busy`=0, `imem_en` stays 0.

Source files
------------

// File: rtl/params_pkg.sv
// params_pkg: shared widths and fetch FSM state encoding
package params_pkg;
   localparam int ADDR_W  = 10;
   localparam int INSTR_W = 16;
   typedef enum logic [1:0] {FS_IDLE, FS_REQ, FS_RESP, FS_HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: reads imem at the PC and hands each word to decode over valid/ready, driving PC updates
module fetch_unit
   import params_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic [ADDR_W-1:0]  pc_curr,
   input  logic [ADDR_W-1:0]  pc_inc,
   output logic               pc_we,
   output logic [ADDR_W-1:0]  pc_next,
   output logic               imem_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_target,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic               busy
);
   fetch_state_t      state, next_state;
   logic [ADDR_W-1:0] pend_pc;
   logic              hs, decide, capture;
   // instr_valid is only ever set in HOLD, so a handshake implies HOLD
   always_comb begin
      hs         = instr_valid & instr_ready;
      decide     = redirect_valid | hs | (state == FS_IDLE);
      capture    = (state == FS_RESP) & ~redirect_valid;
      pc_we      = ~rst & (redirect_valid | hs);
      pc_next    = redirect_valid ? redirect_target : pc_inc;
      imem_en    = ~rst & (state == FS_REQ);
      imem_addr  = pc_curr;
      busy       = state != FS_IDLE;
      next_state = decide ? (run ? FS_REQ : FS_IDLE) :
                   state == FS_REQ  ? FS_RESP :
                   state == FS_RESP ? FS_HOLD : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FS_IDLE;
         pend_pc     <= '0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else begin
         state       <= next_state;
         if (state == FS_REQ) pend_pc <= pc_curr;
         if (capture) begin
            instr    <= imem_rdata;
            instr_pc <= pend_pc;
         end
         instr_valid <= capture | (instr_valid & ~(redirect_valid | hs));
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: fetch_unit with a PC register and synchronous ROM, table, directed and random checks
module tb_fetch_unit;
   import params_pkg::*;
   logic               clk, rst, run, redirect_valid, instr_ready;
   logic [ADDR_W-1:0]  pc_curr, pc_inc, pc_next, imem_addr, redirect_target, instr_pc;
   logic [INSTR_W-1:0] imem_rdata, instr;
   logic               pc_we, imem_en, instr_valid, busy;
   logic [INSTR_W-1:0] rom [1024];
   int checks = 0, failures = 0;

   fetch_unit dut (
      .clk(clk), .rst(rst), .run(run), .pc_curr(pc_curr), .pc_inc(pc_inc),
      .pc_we(pc_we), .pc_next(pc_next), .imem_en(imem_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
      .redirect_target(redirect_target), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (rst) pc_curr <= '0;
      else if (pc_we) pc_curr <= pc_next;
   end
   assign pc_inc = pc_curr + 10'd1;

   initial for (int i = 0; i < 1024; i++) rom[i] = 16'hA000 + 16'(i);
   always_ff @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

   function automatic logic [15:0] word_at(input logic [9:0] a);
      return 16'hA000 + {6'b0, a};
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", n, a, e);
      end
   endtask

   task automatic step(input logic r, input logic ru, input logic rdy, input logic rd, input logic [9:0] t);
      @(negedge clk);
      rst = r; run = ru; instr_ready = rdy; redirect_valid = rd; redirect_target = t;
      #1;
   endtask

   task automatic wait_hold(input logic ru);
      int n = 0;
      do begin
         step(1'b0, ru, 1'b0, 1'b0, 10'd0);
         n++;
      end while (!instr_valid && n < 8);
      chk("hold_reached", 32'(instr_valid), 32'd1);
   endtask

   typedef struct {
      logic       run, ready, v, we, en, bsy;
      logic [9:0] pc, ipc;
      logic [15:0] ins;
   } vec_t;
   vec_t tbl [10];

   logic [9:0]  exp_pc, tg, held_ipc;
   logic [15:0] held_ins;
   logic        prev_hold, rr, rdy, rd;
   int          xfers;

   initial begin
      tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 16'h0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h0, 10'h0, 16'h0};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h0, 10'h0, 16'h0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'h0, 10'h0, 16'hA000};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h1, 10'h0, 16'h0};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h1, 10'h0, 16'h0};
      tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'h1, 10'h1, 16'hA001};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h2, 10'h0, 16'h0};
      tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h2, 10'h0, 16'h0};
      tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'h2, 10'h2, 16'hA002};

      // reset, with redirect and ready asserted to prove reset overrides them
      step(1'b1, 1'b1, 1'b1, 1'b1, 10'h055);
      step(1'b1, 1'b1, 1'b1, 1'b1, 10'h055);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pc_we", 32'(pc_we), 32'd0);
      chk("rst_imem_en", 32'(imem_en), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'(pc_curr));
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_instr_pc", 32'(instr_pc), 32'd0);
      chk("rst_pc", 32'(pc_curr), 32'd0);

      for (int i = 0; i < 10; i++) begin
         step(1'b0, tbl[i].run, tbl[i].ready, 1'b0, 10'd0);
         chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].v));
         chk($sformatf("tbl%0d_pc_we", i), 32'(pc_we), 32'(tbl[i].we));
         chk($sformatf("tbl%0d_imem_en", i), 32'(imem_en), 32'(tbl[i].en));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
         chk($sformatf("tbl%0d_pc", i), 32'(pc_curr), 32'(tbl[i].pc));
         if (tbl[i].en) chk($sformatf("tbl%0d_imem_addr", i), 32'(imem_addr), 32'(tbl[i].pc));
         if (tbl[i].v) begin
            chk($sformatf("tbl%0d_instr", i), 32'(instr), 32'(tbl[i].ins));
            chk($sformatf("tbl%0d_instr_pc", i), 32'(instr_pc), 32'(tbl[i].ipc));
            chk($sformatf("tbl%0d_pc_next", i), 32'(pc_next), 32'(tbl[i].pc + 10'd1));
         end
      end

      // stall five cycles in HOLD
      wait_hold(1'b1);
      chk("stall_instr", 32'(instr), 32'hA003);
      chk("stall_instr_pc", 32'(instr_pc), 32'h3);
      chk("stall_pc_we0", 32'(pc_we), 32'd0);
      for (int i = 1; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
         chk($sformatf("stall%0d_valid", i), 32'(instr_valid), 32'd1);
         chk($sformatf("stall%0d_instr", i), 32'(instr), 32'hA003);
         chk($sformatf("stall%0d_instr_pc", i), 32'(instr_pc), 32'h3);
         chk($sformatf("stall%0d_pc_we", i), 32'(pc_we), 32'd0);
      end
      step(1'b0, 1'b1, 1'b1, 1'b0, 10'd0);
      chk("stall_hs_pc_we", 32'(pc_we), 32'd1);
      chk("stall_hs_pc_next", 32'(pc_next), 32'h4);
      step(1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
      chk("stall_pc_after", 32'(pc_curr), 32'h4);
      chk("stall_req_en", 32'(imem_en), 32'd1);

      // redirect during RESP discards the read
      step(1'b0, 1'b1, 1'b0, 1'b1, 10'h155);
      chk("rresp_pc_we", 32'(pc_we), 32'd1);
      chk("rresp_pc_next", 32'(pc_next), 32'h155);
      step(1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
      chk("rresp_pc", 32'(pc_curr), 32'h155);
      chk("rresp_valid", 32'(instr_valid), 32'd0);
      chk("rresp_req_addr", 32'(imem_addr), 32'h155);
      chk("rresp_req_en", 32'(imem_en), 32'd1);
      wait_hold(1'b1);
      chk("rresp_instr_pc", 32'(instr_pc), 32'h155);
      chk("rresp_instr", 32'(instr), 32'hA155);

      // redirect together with handshake
      step(1'b0, 1'b1, 1'b1, 1'b1, 10'h020);
      chk("rdhs_xfer", 32'(instr_valid & instr_ready), 32'd1);
      chk("rdhs_pc_we", 32'(pc_we), 32'd1);
      chk("rdhs_pc_next", 32'(pc_next), 32'h020);
      step(1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
      chk("rdhs_pc", 32'(pc_curr), 32'h020);
      chk("rdhs_valid", 32'(instr_valid), 32'd0);
      wait_hold(1'b1);
      chk("rdhs_instr_pc", 32'(instr_pc), 32'h020);

      // PC wrap from the top of the address space
      step(1'b0, 1'b1, 1'b1, 1'b1, 10'h3FF);
      wait_hold(1'b1);
      chk("wrap_instr_pc", 32'(instr_pc), 32'h3FF);
      chk("wrap_instr", 32'(instr), 32'hA3FF);
      step(1'b0, 1'b1, 1'b1, 1'b0, 10'd0);
      chk("wrap_pc_we", 32'(pc_we), 32'd1);
      chk("wrap_pc_next", 32'(pc_next), 32'h000);
      wait_hold(1'b1);
      chk("wrap_next_instr_pc", 32'(instr_pc), 32'h000);
      chk("wrap_next_instr", 32'(instr), 32'hA000);

      // reset while holding a valid instruction
      step(1'b1, 1'b1, 1'b1, 1'b1, 10'h0AA);
      chk("rhold_pc_we", 32'(pc_we), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      chk("rhold_valid", 32'(instr_valid), 32'd0);
      chk("rhold_busy", 32'(busy), 32'd0);
      chk("rhold_pc", 32'(pc_curr), 32'h0);
      chk("rhold_imem_en", 32'(imem_en), 32'd0);

      // run dropped at handshake returns to IDLE
      step(1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
      wait_hold(1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
      chk("stop_pc_we", 32'(pc_we), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
         chk($sformatf("stop%0d_busy", i), 32'(busy), 32'd0);
         chk($sformatf("stop%0d_imem_en", i), 32'(imem_en), 32'd0);
      end
      chk("stop_pc", 32'(pc_curr), 32'h1);

      // random traffic against a transfer-level model
      exp_pc = pc_curr;
      xfers = 0;
      for (int c = 0; c < 1500; c++) begin
         prev_hold = instr_valid & ~instr_ready & ~redirect_valid;
         held_ins = instr;
         held_ipc = instr_pc;
         rr  = $urandom_range(0, 9) != 0;
         rdy = $urandom_range(0, 1) == 1;
         rd  = $urandom_range(0, 7) == 0;
         tg  = 10'($urandom);
         step(1'b0, rr, rdy, rd, tg);
         if (prev_hold) begin
            chk("rnd_hold_valid", 32'(instr_valid), 32'd1);
            chk("rnd_hold_instr", 32'(instr), 32'(held_ins));
            chk("rnd_hold_instr_pc", 32'(instr_pc), 32'(held_ipc));
         end
         chk("rnd_pc_we", 32'(pc_we), 32'((instr_valid & instr_ready) | rd));
         if (instr_valid & instr_ready) begin
            xfers++;
            chk("rnd_instr_pc", 32'(instr_pc), 32'(exp_pc));
            chk("rnd_instr", 32'(instr), 32'(word_at(exp_pc)));
         end
         if (rd) exp_pc = tg;
         else if (instr_valid & instr_ready) exp_pc = exp_pc + 10'd1;
      end
      chk("rnd_progress", 32'(xfers > 100), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
